// File: rtl/rv_mem_pkg.sv
// Shared MEM-stage types: funct3 sizing, FSM states, MMIO address.
// Load extension helper used by mem_access_stage.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [7:0] MMIO_ADDR = 8'hFC;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } mem_state_t;

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  lane
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {lane, 3'b000};
    unique case (f3)
      F3_B:    r = {{24{sh[7]}}, sh[7:0]};
      F3_H:    r = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   r = {24'h0, sh[7:0]};
      F3_HU:   r = {16'h0, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-organised data RAM: synchronous read, byte-enabled write.
// Contents are never reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: byte-addressed loads/stores with one-cycle load wait.
// Optional DMEM_MMIO_EN maps word 0xFC to the io_out register.
module mem_access_stage
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  f3,
  input  logic [31:0] aluresult,
  input  logic [31:0] bmux_result,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misaligned,
  output logic        err_sticky
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] io_out
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  mem_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr;
  logic [1:0]  lane;
  logic        legal_f3, align_ok, is_w, is_h;
  logic        do_store, do_load, ram_we, mmio_hit;
  logic [3:0]  be;
  logic [31:0] wdata, rdata, src_word, ext_word, hold_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        unused_hi;

  assign addr      = aluresult[ADDR_W-1:0];
  assign lane      = addr[1:0];
  assign unused_hi = ^aluresult[31:ADDR_W];
  assign is_w      = f3[1:0] == 2'b10;
  assign is_h      = f3[1:0] == 2'b01;

  always_comb begin
    legal_f3 = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    align_ok = 1'b1;
    be       = 4'b0001 << lane;
    wdata    = {4{bmux_result[7:0]}};
    unique case (1'b1)
      is_w: begin
        align_ok = lane == 2'b00;
        be       = 4'b1111;
        wdata    = bmux_result;
      end
      is_h: begin
        align_ok = ~lane[0];
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{bmux_result[15:0]}};
      end
      default: ;
    endcase
  end

  // Inputs are don't-care in LOAD_WAIT: upstream is replaying the same load.
  always_comb begin
    misaligned = 1'b0;
    do_store   = 1'b0;
    do_load    = 1'b0;
    if (state_q == IDLE && (memread || memwrite)) begin
      misaligned = ~(legal_f3 && align_ok);
      do_store   = memwrite && !misaligned;
      do_load    = memread && !memwrite && !misaligned;
    end
  end

`ifdef DMEM_MMIO_EN
  logic mmio_q;

  assign mmio_hit = (addr >> 2) == (ADDR_W'(MMIO_ADDR) >> 2);
  assign src_word = mmio_q ? io_out : rdata;

  always_ff @(posedge clk) begin
    if (do_load) begin
      mmio_q <= mmio_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out <= '0;
    end else if (do_store && mmio_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          io_out[i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end
`else
  assign mmio_hit = 1'b0;
  assign src_word = rdata;
`endif

  assign ram_we = do_store && !mmio_hit;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (be),
    .re   (do_load),
    .addr (addr[AW+1:2]),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (do_load) state_d = LOAD_WAIT;
      LOAD_WAIT: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_load) begin
      f3_q   <= f3;
      lane_q <= lane;
    end
  end

  assign ext_word   = load_ext(src_word, f3_q, lane_q);
  assign load_valid = (state_q == LOAD_WAIT) && !reset;
  assign stall      = do_load && !reset;
  assign load_data  = load_valid ? ext_word : hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (state_q == LOAD_WAIT) hold_q <= ext_word;
      if (misaligned) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage.
// Define DMEM_MMIO_EN to also exercise the io_out window.
module tb_mem_access_stage;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [2:0]  f3;
  logic [31:0] aluresult, bmux_result;
  logic [31:0] load_data;
  logic        load_valid, stall, misaligned, err_sticky;
`ifdef DMEM_MMIO_EN
  logic [31:0] io_out;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk        (clk),
    .reset      (reset),
    .memread    (memread),
    .memwrite   (memwrite),
    .f3         (f3),
    .aluresult  (aluresult),
    .bmux_result(bmux_result),
    .load_data  (load_data),
    .load_valid (load_valid),
    .stall      (stall),
    .misaligned (misaligned),
    .err_sticky (err_sticky)
`ifdef DMEM_MMIO_EN
    ,
    .io_out     (io_out)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f, input logic rd);
    memwrite = 1'b1;
    memread = rd;
    f3 = f;
    aluresult = a;
    bmux_result = d;
    @(negedge clk);
    check("st_stall", stall, 0);
    check("st_mis", misaligned, 0);
    step();
    memwrite = 1'b0;
    memread = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] exp);
    int n;
    logic seen;
    logic [31:0] e;
    memread = 1'b1;
    f3 = f;
    aluresult = a;
    sb_q.push_back(exp);
    @(negedge clk);
    check("ld_stall", stall, 1);
    check("ld_mis", misaligned, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4) begin
      @(negedge clk);
      n++;
      seen = load_valid;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check("ld_timeout", 0, 1);
    end else begin
      check("ld_lat", n, 1);
      check("ld_data", load_data, e);
      check("ld_nostall", stall, 0);
    end
    step();
    memread = 1'b0;
    @(negedge clk);
    check("ld_pulse", load_valid, 0);
    check("ld_hold", load_data, e);
    step();
  endtask

  task automatic bad_access(input logic [31:0] a, input logic [2:0] f,
                            input logic rd, input logic wr);
    memread = rd;
    memwrite = wr;
    f3 = f;
    aluresult = a;
    bmux_result = 32'h0;
    @(negedge clk);
    check("bad_mis", misaligned, 1);
    check("bad_stall", stall, 0);
    check("bad_valid", load_valid, 0);
    step();
    memread = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    check("bad_valid2", load_valid, 0);
    check("bad_sticky", err_sticky, 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=done", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    memread = 1'b0;
    memwrite = 1'b0;
    f3 = F3_W;
    aluresult = '0;
    bmux_result = '0;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", load_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_data", load_data, 0);
    check("rst_sticky", err_sticky, 0);
    step();

    store(32'h10, 32'hDEADBEEF, F3_W, 1'b0);
    load(32'h10, F3_W, 32'hDEADBEEF);

    store(32'h20, 32'h11223344, F3_W, 1'b0);
    store(32'h21, 32'h00000080, F3_B, 1'b0);
    load(32'h21, F3_B, 32'hFFFFFF80);
    load(32'h21, F3_BU, 32'h00000080);
    store(32'h22, 32'h00008001, F3_H, 1'b0);
    load(32'h22, F3_H, 32'hFFFF8001);
    load(32'h22, F3_HU, 32'h00008001);
    load(32'h20, F3_W, 32'h80018044);
    load(32'h20, F3_B, 32'h00000044);

    @(negedge clk);
    check("pre_sticky", err_sticky, 0);
    step();

    bad_access(32'h13, F3_W, 1'b1, 1'b0);
    bad_access(32'h13, F3_W, 1'b0, 1'b1);
    load(32'h10, F3_W, 32'hDEADBEEF);
    bad_access(32'h10, 3'b011, 1'b1, 1'b0);
    bad_access(32'h21, F3_H, 1'b0, 1'b1);
    bad_access(32'h20, 3'b110, 1'b1, 1'b0);
    load(32'h20, F3_W, 32'h80018044);

    store(32'h1F4, 32'hCAFEF00D, F3_W, 1'b0);
    load(32'hF4, F3_W, 32'hCAFEF00D);

    store(32'h30, 32'h00000055, F3_W, 1'b1);
    load(32'h30, F3_W, 32'h00000055);

    memread = 1'b1;
    f3 = F3_W;
    aluresult = 32'h10;
    @(negedge clk);
    check("rl_stall", stall, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    memread = 1'b0;
    @(negedge clk);
    check("rl_valid", load_valid, 0);
    check("rl_stall0", stall, 0);
    check("rl_data", load_data, 0);
    check("rl_sticky", err_sticky, 0);
    step();
    load(32'h10, F3_W, 32'hDEADBEEF);

`ifdef DMEM_MMIO_EN
    @(negedge clk);
    check("io_rst", io_out, 0);
    step();
    store(32'hFC, 32'h12345678, F3_W, 1'b0);
    @(negedge clk);
    check("io_word", io_out, 32'h12345678);
    step();
    load(32'hFD, F3_BU, 32'h00000056);
    store(32'hFE, 32'h0000ABCD, F3_H, 1'b0);
    load(32'hFC, F3_W, 32'hABCD5678);
`else
    store(32'hFC, 32'h12345678, F3_W, 1'b0);
    load(32'hFD, F3_BU, 32'h00000056);
    load(32'hFC, F3_W, 32'h12345678);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its memory-control, address and store-data fields.
- Holds the byte-addressable data RAM. Performs loads and stores with funct3 sizing, and returns sign- or zero-extended load data toward the MEM/WB register.
- Loads need one wait cycle: the RAM has a synchronous read, so the stage stalls the upstream pipeline for one cycle.

Parameters:
- ADDR_W, 8, byte-address width taken from aluresult[ADDR_W-1:0] (matches 8-bit PC/address space)
- DEPTH_WORDS, 64, number of 32-bit RAM words (256 bytes)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- memread  in  1  load request from EX/MEM register
- memwrite  in  1  store request from EX/MEM register
- f3  in  3  funct3 access size/sign
- aluresult  in  32  effective byte address
- bmux_result  in  32  store data (rs2)
- load_data  out  32  extended load result, valid when load_valid=1
- load_valid  out  1  one-cycle pulse; load_data is valid
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers this cycle
- misaligned  out  1  combinational; current access is misaligned or has an illegal f3
- err_sticky  out  1  registered; set by any misaligned/illegal access, cleared only by reset
- io_out  out  32  MMIO output register (present only with DMEM_MMIO_EN)

Behaviour:
- Reset (synchronous, active-high, takes priority over everything else):
  - state goes to IDLE.
  - load_data=0, load_valid=0, stall=0, err_sticky=0, io_out=0.
  - RAM contents are not cleared.
  - Reset during LOAD_WAIT aborts the load; no load_valid pulse is produced.
- FSM states: IDLE, LOAD_WAIT.
- IDLE, memwrite=1 and aligned:
  - Byte-enabled write at the posedge, per f3: sb 000, sh 001, sw 010.
  - Lane is selected by addr[1:0]. No stall. State stays IDLE.
- IDLE, memread=1 (memwrite=0) and aligned:
  - stall=1 combinationally this cycle.
  - RAM read is registered at the posedge. f3 and addr[1:0] are captured. State goes to LOAD_WAIT.
- LOAD_WAIT:
  - stall=0; load_valid=1; load_data = extended word.
  - State returns to IDLE at the next posedge.
  - Inputs are ignored in this state (upstream was held, so they repeat the same load).
- Load extension:
  - lb 000 sign-extends byte; lh 001 sign-extends half; lw 010 returns the full word.
  - lbu 100 zero-extends byte; lhu 101 zero-extends half.
- Alignment rules:
  - Halfword accesses require addr[0]=0. Word accesses require addr[1:0]=00.
  - f3 011, 110, 111 are illegal.
  - Misaligned or illegal access: no RAM write, no stall, load_valid=0, misaligned=1 that cycle, err_sticky set at the posedge.
- memread and memwrite both high: the store executes and the load is ignored.
- Address bits above log2(DEPTH_WORDS*4) are ignored, so addresses wrap modulo the RAM size.
- Store followed by a load of the same address in the next cycle returns the new data; the write lands before the read posedge.
- load_data holds its last value when load_valid=0.
- Latency:
  - Load: 2 cycles (issue cycle plus one stall cycle).
  - Store: 1 cycle.

Optional Feature:
- DMEM_MMIO_EN defined:
  - Word address 0xFC (byte addresses 0xFC-0xFF) maps to the io_out register instead of RAM.
  - Stores there obey the byte enables. Loads there return io_out with normal extension and the same 1-cycle wait.
- Undefined: io_out port absent; 0xFC is ordinary RAM.

Decomposition:
- Package rv_mem_pkg holds:
  - f3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - mem_state_t enum {IDLE, LOAD_WAIT}.
  - MMIO_ADDR constant 8'hFC.
- Sub-module dmem_ram: DEPTH_WORDS x 32 RAM with synchronous read and 4-bit byte-enable write; one instance.

Test Plan:
- Store then load word: sw 0xDEADBEEF to 0x10, then lw 0x10. Store takes 1 cycle with no stall. Load asserts stall for 1 cycle, then load_valid=1 with load_data=0xDEADBEEF.
- Byte and half extension: sb 0x80 to 0x21, then lb 0x21 returns 0xFFFFFF80. lbu 0x21 returns 0x00000080. sh 0x8001 to 0x22, then lh returns 0xFFFF8001.
- Misalignment: lw at 0x13 gives misaligned=1, stall=0, no load_valid, err_sticky=1 on the next cycle. sw at 0x13 leaves word 0x10 unchanged.
- Illegal f3: memread with f3=011 is flagged as misaligned and produces no load_valid. Wrap check: sw to 0x1F4 lands at 0xF4.
- Reset mid-load: assert reset during LOAD_WAIT. Next cycle shows load_valid=0, stall=0, load_data=0, err_sticky=0. Previously stored RAM data is still readable.
- With DMEM_MMIO_EN: sw 0x12345678 to 0xFC gives io_out=0x12345678, and RAM word 63 is untouched. lbu 0xFD returns 0x00000056.
